// File: rtl/vga_test.sv
// 640x480 VGA timing generator: strobe-gated h/v counters decoded into syncs,
// blanking, frame events and visible pixel coordinates.
module vga_test #(
    parameter logic [9:0] HS_STA = 10'd16,
    parameter logic [9:0] HS_END = 10'd112,
    parameter logic [9:0] HA_STA = 10'd160,
    parameter logic [9:0] VS_STA = 10'd490,
    parameter logic [9:0] VS_END = 10'd492,
    parameter logic [9:0] VA_END = 10'd480,
    parameter logic [9:0] LINE   = 10'd800,
    parameter logic [9:0] SCREEN = 10'd525
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_blanking,
    output logic       o_active,
    output logic       o_screenend,
    output logic       o_animate,
    output logic [9:0] o_x,
    output logic [8:0] o_y
);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       line_end;

    assign line_end = (h_count == LINE - 10'd1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (i_pix_stb) begin
            if (line_end) begin
                h_count <= '0;
                if (v_count == SCREEN - 10'd1)
                    v_count <= '0;
                else
                    v_count <= v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    // Pure decode of the registered counters: zero latency to every output.
    always_comb begin
        o_hs        = ~((h_count >= HS_STA) && (h_count < HS_END));
        o_vs        = ~((v_count >= VS_STA) && (v_count < VS_END));
        o_blanking  = (h_count < HA_STA) || (v_count >= VA_END);
        o_active    = ~o_blanking;
        o_screenend = (v_count == SCREEN - 10'd1) && line_end;
        o_animate   = (v_count == VA_END - 10'd1) && line_end;
        o_x         = (h_count < HA_STA) ? '0 : (h_count - HA_STA);
        // Row saturates at the last visible line through vertical blanking.
        o_y         = (v_count >= VA_END) ? 9'(VA_END - 10'd1) : v_count[8:0];
    end

endmodule

// File: tb/tb_vga_test.sv
// Bench for vga_test: full-size instance for line timing, shrunken instance
// for whole-frame timing, both checked against a strobe-count reference model.
module tb_vga_test;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_pix_stb = 1'b0;

    logic       f_hs, f_vs, f_bl, f_ac, f_se, f_an;
    logic [9:0] f_x;
    logic [8:0] f_y;
    logic       s_hs, s_vs, s_bl, s_ac, s_se, s_an;
    logic [9:0] s_x;
    logic [8:0] s_y;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n = 0;          // strobed edges since reset
    int unsigned last_se_n = 0;
    bit          have_se = 0;

    always #5 i_clk = ~i_clk;

    vga_test u_full (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .o_hs(f_hs), .o_vs(f_vs), .o_blanking(f_bl), .o_active(f_ac),
        .o_screenend(f_se), .o_animate(f_an), .o_x(f_x), .o_y(f_y)
    );

    vga_test #(
        .HS_STA(10'd4), .HS_END(10'd10), .HA_STA(10'd12),
        .VS_STA(10'd24), .VS_END(10'd26), .VA_END(10'd20),
        .LINE(10'd40), .SCREEN(10'd30)
    ) u_small (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .o_hs(s_hs), .o_vs(s_vs), .o_blanking(s_bl), .o_active(s_ac),
        .o_screenend(s_se), .o_animate(s_an), .o_x(s_x), .o_y(s_y)
    );

    typedef struct {
        logic       hs, vs, bl, ac, se, an;
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    function automatic exp_t model(int unsigned cnt, int unsigned hss, int unsigned hse,
                                   int unsigned has, int unsigned vss, int unsigned vse,
                                   int unsigned vae, int unsigned line, int unsigned screen);
        exp_t e;
        int unsigned h = cnt % line;
        int unsigned v = (cnt / line) % screen;
        e.hs = !(h >= hss && h < hse);
        e.vs = !(v >= vss && v < vse);
        e.bl = (h < has) || (v >= vae);
        e.ac = !e.bl;
        e.se = (h == line - 1) && (v == screen - 1);
        e.an = (h == line - 1) && (v == vae - 1);
        e.x  = 10'((h < has) ? 0 : h - has);
        e.y  = 9'((v >= vae) ? vae - 1 : v);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_inst(input string tag, input exp_t e,
                              input logic hs, input logic vs, input logic bl, input logic ac,
                              input logic se, input logic an, input logic [9:0] x,
                              input logic [8:0] y);
        chk({tag, ".hs"}, 32'(hs), 32'(e.hs));
        chk({tag, ".vs"}, 32'(vs), 32'(e.vs));
        chk({tag, ".blanking"}, 32'(bl), 32'(e.bl));
        chk({tag, ".active"}, 32'(ac), 32'(e.ac));
        chk({tag, ".screenend"}, 32'(se), 32'(e.se));
        chk({tag, ".animate"}, 32'(an), 32'(e.an));
        chk({tag, ".x"}, 32'(x), 32'(e.x));
        chk({tag, ".y"}, 32'(y), 32'(e.y));
    endtask

    task automatic check_all(input string tag);
        check_inst({tag, ".full"}, model(n, 16, 112, 160, 490, 492, 480, 800, 525),
                   f_hs, f_vs, f_bl, f_ac, f_se, f_an, f_x, f_y);
        check_inst({tag, ".small"}, model(n, 4, 10, 12, 24, 26, 20, 40, 30),
                   s_hs, s_vs, s_bl, s_ac, s_se, s_an, s_x, s_y);
        // Distinct screenend states on the small instance must be one frame apart.
        if (s_se && (!have_se || n != last_se_n)) begin
            if (have_se) chk("screenend_interval", n - last_se_n, 32'd1200);
            have_se   = 1;
            last_se_n = n;
        end
    endtask

    task automatic do_step(input string tag, input logic stb);
        i_pix_stb = stb;
        @(posedge i_clk);
        if (stb && !i_rst) n++;
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held with random strobes: outputs frozen at reset decode.
        i_rst = 1'b1;
        for (int i = 0; i < 10; i++) do_step("reset", 1'($urandom));

        // Release reset, then strobe every second clock.
        #1 i_rst = 1'b0;
        for (int i = 0; i < 40; i++) do_step("gating", 1'(i % 2));
        chk("gating_count", n, 32'd20);

        // Continuous strobes: three full lines and two small-instance frames.
        for (int i = 0; i < 2500; i++) do_step("run", 1'b1);

        // Random strobe density.
        for (int i = 0; i < 1500; i++) do_step("random", 1'($urandom_range(3, 0) != 0));

        // Reach h=300 on the full instance, then reset asynchronously mid-line.
        for (int k = 0; k < 1000 && (n % 800) != 300; k++) do_step("seek", 1'b1);
        chk("reach_h300", n % 800, 32'd300);
        #1 i_rst = 1'b1;
        #1;
        n = 0;
        have_se = 0;
        check_all("async_rst");
        for (int i = 0; i < 3; i++) do_step("rst_hold", 1'b1);
        i_rst = 1'b0;
        for (int i = 0; i < 1300; i++) do_step("restart", 1'($urandom_range(7, 0) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_test.md
Name: vga_test

Overview:
- 640x480 VGA timing generator; horizontal/vertical counters advance on a pixel-strobe clock enable.
- Decodes the counters into active-low sync pulses, blanking/active flags, frame-event pulses and pixel coordinates.
- Sits between the system clock/strobe divider and the pixel renderer / VGA output pins.

Parameters:
- HS_STA, 16, h count where HSYNC assertion starts (front porch length)
- HS_END, 112, h count where HSYNC deasserts (16+96)
- HA_STA, 160, first h count of active video (16+96+48)
- VS_STA, 490, v count where VSYNC assertion starts (480+10)
- VS_END, 492, v count where VSYNC deasserts (490+2)
- VA_END, 480, first v count after active video
- LINE, 800, total h counts per line
- SCREEN, 525, total lines per frame

Ports:
- i_clk  input  1  system clock; all state updates on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_pix_stb  input  1  pixel clock enable; counters advance only on edges where it is 1
- o_hs  output  1  horizontal sync, active low
- o_vs  output  1  vertical sync, active low
- o_blanking  output  1  high outside the visible area
- o_active  output  1  high inside the visible area (exact inverse of o_blanking)
- o_screenend  output  1  high for the last pixel of the frame
- o_animate  output  1  high for the last pixel of the last active line
- o_x  output  10  visible pixel column, 0..639
- o_y  output  9  visible pixel row, 0..479

Behaviour:
- Internal state: h_count[9:0] and v_count[9:0]. Reset value is 0 for both; reset is asynchronous on the rising edge of i_rst and dominates i_pix_stb.
- On a rising i_clk edge with i_pix_stb=1:
  - If h_count == LINE-1: h_count <= 0. Then, if v_count == SCREEN-1, v_count <= 0; otherwise v_count <= v_count+1.
  - Otherwise: h_count <= h_count+1.
- With i_pix_stb=0 the counters hold their values.
- Frame length is exactly LINE*SCREEN = 420000 strobes.
- All outputs are combinational decodes of the registered counters. Latency is 0 cycles from a counter value to its outputs.
- Decodes:
  - o_hs = ~(HS_STA <= h_count < HS_END)
  - o_vs = ~(VS_STA <= v_count < VS_END)
  - o_blanking = (h_count < HA_STA) | (v_count >= VA_END)
  - o_active = ~o_blanking
  - o_screenend = (v_count == SCREEN-1) & (h_count == LINE-1)
  - o_animate = (v_count == VA_END-1) & (h_count == LINE-1)
  - o_x = 0 when h_count < HA_STA, else h_count - HA_STA (10 bits; max 639)
  - o_y = VA_END-1 (479) when v_count >= VA_END, else v_count[8:0]
- Output values while in reset / just after reset (h=0, v=0): o_hs=1, o_vs=1, o_blanking=1, o_active=0, o_screenend=0, o_animate=0, o_x=0, o_y=0.
- o_screenend and o_animate are level-high for the full duration of their counter state. That state spans one strobe period, which may cover multiple i_clk cycles.
- Reset asserted mid-frame returns both counters to 0 immediately. Counting resumes on the first strobed edge after i_rst falls.

Test Plan:
- Reset: i_rst=1, random i_pix_stb -> o_x=0, o_y=0, o_hs=1, o_vs=1, o_blanking=1, o_active=0, counters frozen.
- Strobe gating: i_clk period 10 ns, i_pix_stb toggling every 10 ns, i_rst=0 -> h_count advances on every second i_clk edge only.
- Line timing:
  - o_hs goes low exactly 16 strobes after line start and stays low for 96 strobes.
  - o_active rises at strobe 160 of lines 0..479 with o_x=0, and o_x=639 at strobe 799.
  - After strobe 799, h wraps to 0 and o_y increments.
- Frame timing:
  - o_vs is low only on lines 490 and 491.
  - o_y saturates at 479 during lines 480..524.
  - o_blanking=1 for the whole of lines 480..524.
- Events:
  - o_animate is high only at (h=799, v=479).
  - o_screenend is high only at (h=799, v=524); the next strobe gives h=0, v=0.
  - Exactly 420000 strobes separate consecutive o_screenend pulses.
- Mid-frame reset: assert i_rst at (h=300, v=200) for one cycle -> outputs return to reset values asynchronously, and counting restarts from (0,0).
